lcd_cmd_ctrl: RTL and testbench

Hardware command engine for the HD44780-compatible character LCD on the board I/O bus. It replaces software bit-banging of the LCD register. After reset it runs the controller power-up and initialisation sequence autonomously. It then accepts one command or data byte per valid/ready handshake from the CPU's LSU peripheral side, and generates the EN strobe with setup, pulse, hold and execution-wait timing. It drives both discrete LCD pins and the packed 32-bit LCD word used by the existing I/O map.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_timer.sv | 28 ++
 rtl/lcd_cmd_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lcd_cmd_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, init ROM and io_lcd layout for the LCD command engine
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  // HD44780 8-bit init: function set x4, display on, clear, entry mode
  localparam int         INIT_LEN = 7;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Bit positions inside the packed io_lcd word
  localparam int IO_ON_BIT = 31;
  localparam int IO_EN_BIT = 10;
  localparam int IO_RS_BIT = 9;
  localparam int IO_RW_BIT = 8;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  // The first three function-set writes run before the busy flag is valid, so they get the long wait
  function automatic logic init_step_long(input logic [2:0] step);
    return (step < 3'd3) || (INIT_ROM[step] == 8'h01);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable saturating down-counter shared by all timed LCD states
module lcd_timer #(
  parameter int WIDTH     = 8,
  parameter int RST_VALUE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and stick at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= WIDTH'(RST_VALUE);
    end else if (load_i) begin
      count <= value_i;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired_o = (count == '0);

endmodule

// File: rtl/lcd_cmd_ctrl.sv
// rtl/lcd_cmd_ctrl.sv - HD44780 command engine: power-up init, request handshake, EN strobe timing
module lcd_cmd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 750000,
  parameter int T_AS    = 2,
  parameter int T_PW    = 12,
  parameter int T_H     = 1,
  parameter int T_SHORT = 2000,
  parameter int T_LONG  = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        req_ready_o,
  output logic        busy_o,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o,
  output logic [31:0] io_lcd_o
);

  localparam int M1    = (T_PWRUP > T_AS) ? T_PWRUP : T_AS;
  localparam int M2    = (M1 > T_PW) ? M1 : T_PW;
  localparam int M3    = (M2 > T_H) ? M2 : T_H;
  localparam int M4    = (M3 > T_SHORT) ? M3 : T_SHORT;
  localparam int T_MAX = (M4 > T_LONG) ? M4 : T_LONG;
  localparam int CNT_W = $clog2(T_MAX + 1);

  // A state lasting N cycles loads N-1: the transition fires on the edge after the count reads zero
  localparam logic [CNT_W-1:0] AS_LOAD    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_LOAD    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_LOAD     = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(T_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(T_LONG - 1);
  localparam logic [2:0]       LAST_STEP  = 3'(INIT_LEN - 1);

  lcd_state_e       state;
  logic [2:0]       step;
  logic [2:0]       next_step;
  logic             init_done;
  logic             cmd_long;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expired;

  assign next_step = step + 3'd1;
  assign lcd_rw_o  = 1'b0;

  // Reset loads the power-up wait so PWRUP spans exactly T_PWRUP cycles after release
  lcd_timer #(
    .WIDTH     (CNT_W),
    .RST_VALUE (T_PWRUP)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  // Reload the timer on every state transition with the duration of the state being entered
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ST_PWRUP: begin
        tmr_load  = tmr_expired;
        tmr_value = AS_LOAD;
      end
      ST_IDLE: begin
        tmr_load  = req_ready_o & req_valid_i;
        tmr_value = AS_LOAD;
      end
      ST_SETUP: begin
        tmr_load  = tmr_expired;
        tmr_value = PW_LOAD;
      end
      ST_PULSE: begin
        tmr_load  = tmr_expired;
        tmr_value = H_LOAD;
      end
      ST_HOLD: begin
        tmr_load  = tmr_expired;
        tmr_value = cmd_long ? LONG_LOAD : SHORT_LOAD;
      end
      ST_WAIT: begin
        tmr_load  = tmr_expired & ~init_done & (step != LAST_STEP);
        tmr_value = AS_LOAD;
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  // Sequencer: init ROM walk, request acceptance and EN strobe, all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_PWRUP;
      step        <= 3'd0;
      init_done   <= 1'b0;
      cmd_long    <= 1'b0;
      req_ready_o <= 1'b0;
      busy_o      <= 1'b1;
      lcd_on_o    <= 1'b0;
      lcd_en_o    <= 1'b0;
      lcd_rs_o    <= 1'b0;
      lcd_data_o  <= 8'h00;
    end else begin
      lcd_on_o <= 1'b1;
      case (state)
        ST_PWRUP: begin
          if (tmr_expired) begin
            state      <= ST_SETUP;
            step       <= 3'd0;
            lcd_rs_o   <= 1'b0;
            lcd_data_o <= INIT_ROM[0];
            cmd_long   <= init_step_long(3'd0);
          end
        end
        ST_IDLE: begin
          if (req_ready_o && req_valid_i) begin
            state       <= ST_SETUP;
            lcd_rs_o    <= req_rs_i;
            lcd_data_o  <= req_data_i;
            cmd_long    <= is_long_cmd(req_rs_i, req_data_i);
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tmr_expired) begin
            state    <= ST_PULSE;
            lcd_en_o <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tmr_expired) begin
            state    <= ST_HOLD;
            lcd_en_o <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (tmr_expired) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tmr_expired) begin
            if (!init_done && (step != LAST_STEP)) begin
              state      <= ST_SETUP;
              step       <= next_step;
              lcd_rs_o   <= 1'b0;
              lcd_data_o <= INIT_ROM[next_step];
              cmd_long   <= init_step_long(next_step);
            end else begin
              state       <= ST_IDLE;
              init_done   <= 1'b1;
              req_ready_o <= 1'b1;
              busy_o      <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_PWRUP;
        end
      endcase
    end
  end

  // Pack the pin state into the legacy I/O-map word
  always_comb begin
    io_lcd_o            = '0;
    io_lcd_o[IO_ON_BIT] = lcd_on_o;
    io_lcd_o[IO_EN_BIT] = lcd_en_o;
    io_lcd_o[IO_RS_BIT] = lcd_rs_o;
    io_lcd_o[IO_RW_BIT] = lcd_rw_o;
    io_lcd_o[7:0]       = lcd_data_o;
  end

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// tb/tb_lcd_cmd_ctrl.sv - directed self-checking bench for lcd_cmd_ctrl
module tb_lcd_cmd_ctrl;

  localparam int T_PWRUP = 20;
  localparam int T_AS    = 2;
  localparam int T_PW    = 3;
  localparam int T_H     = 1;
  localparam int T_SHORT = 8;
  localparam int T_LONG  = 30;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rs    = 1'b0;
  logic [7:0]  req_data  = 8'h00;
  logic        req_ready;
  logic        busy;
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic [31:0] io_lcd;

  always #5 clk = ~clk;

  lcd_cmd_ctrl #(
    .T_PWRUP (T_PWRUP),
    .T_AS    (T_AS),
    .T_PW    (T_PW),
    .T_H     (T_H),
    .T_SHORT (T_SHORT),
    .T_LONG  (T_LONG)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_rs_i    (req_rs),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .busy_o      (busy),
    .lcd_on_o    (lcd_on),
    .lcd_en_o    (lcd_en),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_data_o  (lcd_data),
    .io_lcd_o    (io_lcd)
  );

  // cycle 0 is the first rising edge that samples rst low
  int cyc = -1;
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  int          en_start[$];
  int          en_end[$];
  logic [7:0]  en_data[$];
  logic        en_rs[$];
  logic [31:0] en_io[$];
  logic        prev_en = 1'b0;

  // record every EN pulse seen at the falling edge
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      en_start.push_back(cyc);
      en_data.push_back(lcd_data);
      en_rs.push_back(lcd_rs);
      en_io.push_back(io_lcd);
    end
    if (!lcd_en && prev_en) en_end.push_back(cyc - 1);
    prev_en = lcd_en;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_ready(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) check({tag, "_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic wait_cycle(input int n);
    for (int i = 0; i < 1000; i++) begin
      if (cyc >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    acc       = -1;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) check("send_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int         c;
    int         r;
    int         base;
    int         idx;
    bit         adv;
    int         acc[3];
    logic [7:0] bytes[3];
    logic [7:0] rom[7];
    int         exp_start[7];

    rom       = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    exp_start = '{22, 58, 94, 130, 144, 158, 194};
    bytes     = '{8'h48, 8'h49, 8'h21};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_on", 32'(lcd_on), 32'd0);
    check("rst_io", io_lcd, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("on_cycle0", 32'(lcd_on), 32'd1);
    check("busy_cycle0", 32'(busy), 32'd1);
    check("rw_low", 32'(lcd_rw), 32'd0);

    // 1: autonomous init
    wait_ready("init", r);
    check("init_ready_cycle", r, 206);
    check("init_pulse_count", en_start.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < en_start.size()) begin
        check($sformatf("init_data%0d", k), 32'(en_data[k]), 32'(rom[k]));
        check($sformatf("init_rs%0d", k), 32'(en_rs[k]), 32'd0);
        check($sformatf("init_start%0d", k), en_start[k], exp_start[k]);
      end
    end

    // 2: data write 0x41
    base = en_start.size();
    send(1'b1, 8'h41, c);
    check("data_accept_cycle", c, 206);
    wait_ready("data", r);
    check("data_ready_lat", r - c, 15);
    check("data_pulses", en_start.size() - base, 1);
    if (en_start.size() > base && en_end.size() > base) begin
      check("data_en_start", en_start[base] - c, 3);
      check("data_en_end", en_end[base] - c, 5);
      check("data_byte", 32'(en_data[base]), 32'h41);
      check("data_rs", 32'(en_rs[base]), 32'd1);
      check("data_io", en_io[base], 32'h8000_0641);
    end

    // 3: clear display takes the long wait
    send(1'b0, 8'h01, c);
    wait_ready("clear", r);
    check("clear_ready_lat", r - c, 37);

    // 4: valid held high across three bytes
    base      = en_start.size();
    idx       = 0;
    adv       = 1'b0;
    req_rs    = 1'b1;
    req_data  = bytes[0];
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (adv) begin
        adv = 1'b0;
        if (idx == 3) begin
          req_valid = 1'b0;
          break;
        end
        req_data = bytes[idx];
      end else if (req_ready) begin
        acc[idx] = cyc;
        idx++;
        adv = 1'b1;
      end
      @(negedge clk);
    end
    check("burst_accepts", idx, 3);
    if (idx == 3) begin
      check("burst_gap1", acc[1] - acc[0], 15);
      check("burst_gap2", acc[2] - acc[1], 15);
    end
    wait_ready("burst", r);
    check("burst_pulses", en_start.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < en_start.size())
        check($sformatf("burst_byte%0d", k), 32'(en_data[base + k]), 32'(bytes[k]));
    end

    // 5: reset during PULSE, then 6: request pending through the replayed init
    send(1'b1, 8'h55, c);
    wait_cycle(c + 4);
    check("pre_rst_en", 32'(lcd_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_en", 32'(lcd_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_io", io_lcd, 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    base = en_start.size();
    wait_cycle(50);
    send(1'b1, 8'h5A, c);
    check("replay_accept_cycle", c, 206);
    check("replay_pulses", en_start.size() - base, 7);
    for (int k = 0; k < 7; k++) begin
      if (base + k < en_start.size())
        check($sformatf("replay_data%0d", k), 32'(en_data[base + k]), 32'(rom[k]));
    end
    wait_ready("pending", r);
    if (en_start.size() > base + 7) begin
      check("pending_byte", 32'(en_data[base + 7]), 32'h5A);
      check("pending_rs", 32'(en_rs[base + 7]), 32'd1);
      check("pending_en_start", en_start[base + 7], 209);
    end else begin
      check("pending_pulse_seen", en_start.size(), base + 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
